// File: rtl/transpose_pingpong_buffer.sv
// Ping-pong N x N transposer: rows are written into one bank while
// columns are read from the other, giving one beat per cycle sustained.
module transpose_pingpong_buffer #(
  parameter int DATA_WIDTH     = 16,
  parameter int SYSTOLIC_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_sync,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] in_data,
  input  logic                                 in_rev,
  input  logic                                 flush,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] out_data,
  output logic                                 out_last,
  output logic [1:0]                           level
);

  localparam int N  = SYSTOLIC_WIDTH;
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [N*W-1:0] mem [2][N];
  logic [1:0]     full;
  logic [1:0]     rev;
  logic           wr_bank;
  logic           rd_bank;
  logic [CW-1:0]  row_cnt;
  logic [CW-1:0]  col_cnt;
  logic [CW-1:0]  rd_col;
  logic [N*W-1:0] col_data;
  logic [N*W-1:0] hold;
  logic           in_fire;
  logic           out_fire;

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign in_fire   = in_valid && in_ready && !flush;
  assign out_fire  = out_valid && out_ready;
  assign out_last  = out_valid && (col_cnt == LAST);
  assign level     = {1'b0, full[0]} + {1'b0, full[1]};
  assign rd_col    = rev[rd_bank] ? LAST - col_cnt : col_cnt;

  always_comb begin
    col_data = '0;
    for (int r = 0; r < N; r++) begin
      col_data[r*W +: W] = mem[rd_bank][r][int'(rd_col)*W +: W];
    end
  end

  // Hold the last emitted column while no bank is ready to drain
  assign out_data = out_valid ? col_data : hold;

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < N; r++) begin
          mem[b][r] <= '0;
        end
      end
      full    <= '0;
      rev     <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      row_cnt <= '0;
      col_cnt <= '0;
      hold    <= '0;
    end else begin
      if (flush) begin
        row_cnt <= '0;
      end else if (in_fire) begin
        mem[wr_bank][row_cnt] <= in_data;
        if (row_cnt == '0) begin
          rev[wr_bank] <= in_rev;
        end
        if (row_cnt == LAST) begin
          row_cnt       <= '0;
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
        end else begin
          row_cnt <= row_cnt + 1'b1;
        end
      end
      if (out_fire) begin
        hold <= col_data;
        if (col_cnt == LAST) begin
          col_cnt       <= '0;
          full[rd_bank] <= 1'b0;
          rd_bank       <= !rd_bank;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_transpose_pingpong_buffer.sv
// Bench for transpose_pingpong_buffer: directed scenarios plus random
// traffic, checked every cycle against a matrix-queue reference model.
module tb_transpose_pingpong_buffer;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int DW = N * W;

  typedef logic [N*N*W-1:0] mat_t;

  logic          clk = 1'b0;
  logic          rst_sync;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_rev;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    level;

  int checks = 0;
  int errors = 0;

  mat_t          mq[$];
  bit            rq[$];
  mat_t          part;
  bit            part_rev;
  int            prow;
  int            mcol;
  logic [DW-1:0] last_out;
  bit            armed;
  bit            in_acc;
  bit            out_acc;

  transpose_pingpong_buffer #(
    .DATA_WIDTH(W),
    .SYSTOLIC_WIDTH(N)
  ) dut (
    .clk(clk),
    .rst_sync(rst_sync),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_rev(in_rev),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .level(level)
  );

  always #5 clk = ~clk;

  // Expected column: transpose of the oldest complete matrix
  function automatic logic [DW-1:0] exp_col();
    logic [DW-1:0] v;
    int c;
    if (mq.size() == 0) return last_out;
    c = rq[0] ? N - 1 - mcol : mcol;
    for (int r = 0; r < N; r++) begin
      v[r*W +: W] = mq[0][(r*N + c)*W +: W];
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] arow(input int base, input int r);
    logic [DW-1:0] v;
    for (int c = 0; c < N; c++) begin
      v[c*W +: W] = W'(base + r*16 + c);
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit iv, input logic [DW-1:0] id,
                     input bit irev, input bit fl,
                     input bit ordy, input bit rst);
    bit ifire;
    bit ofire;
    logic [DW-1:0] ecol;
    in_valid  = iv;
    in_data   = id;
    in_rev    = irev;
    flush     = fl;
    out_ready = ordy;
    rst_sync  = rst;
    #1;
    if (armed) begin
      chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("out_last", 64'(out_last),
          64'(mq.size() > 0 && mcol == N - 1));
      chk("level", 64'(level), 64'(mq.size()));
      chk("out_data", out_data, exp_col());
    end
    ifire = iv && (mq.size() < 2) && !fl;
    ofire = (mq.size() > 0) && ordy;
    ecol  = exp_col();
    @(posedge clk);
    in_acc  = ifire && !rst;
    out_acc = ofire && !rst;
    if (rst) begin
      mq.delete();
      rq.delete();
      prow     = 0;
      mcol     = 0;
      last_out = '0;
      armed    = 1'b1;
    end else begin
      if (ofire) begin
        last_out = ecol;
        mcol++;
        if (mcol == N) begin
          void'(mq.pop_front());
          void'(rq.pop_front());
          mcol = 0;
        end
      end
      if (fl) begin
        prow = 0;
      end else if (ifire) begin
        if (prow == 0) part_rev = irev;
        part[prow*DW +: DW] = id;
        prow++;
        if (prow == N) begin
          mq.push_back(part);
          rq.push_back(part_rev);
          prow = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int k;
    int budget;
    bit pend;
    logic [DW-1:0] pdata;
    bit prev;
    armed = 1'b0;
    prow  = 0;
    mcol  = 0;
    part  = '0;
    last_out = '0;
    @(negedge clk);

    // Reset
    cyc(0, '0, 0, 0, 0, 1);
    cyc(0, '0, 0, 0, 0, 1);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_out_data", out_data, 64'd0);

    // Single matrix, natural column order
    for (int r = 0; r < N; r++) cyc(1, arow(0, r), 0, 0, 1, 0);
    chk("m0_valid", 64'(out_valid), 64'd1);
    chk("m0_beat0", out_data, 64'h0030_0020_0010_0000);
    for (int i = 0; i < N + 2; i++) cyc(0, '0, 0, 0, 1, 0);
    chk("m0_hold", out_data, 64'h0033_0023_0013_0003);

    // Reversed column order; in_rev ignored after row 0
    for (int r = 0; r < N; r++) cyc(1, arow(0, r), (r == 0) | r[0], 0, 1, 0);
    chk("rev_beat0", out_data, 64'h0033_0023_0013_0003);
    for (int i = 0; i < N + 2; i++) cyc(0, '0, 0, 0, 1, 0);
    chk("rev_hold", out_data, 64'h0030_0020_0010_0000);

    // Back-to-back matrices, no bubbles
    for (int i = 0; i < 14; i++) begin
      cyc(i < 8, arow(i < 4 ? 'h100 : 'h200, i % 4), 0, 0, 1, 0);
      chk("b2b_level", 64'(level <= 2'd1), 64'd1);
    end

    // Output stalled while three matrices are offered
    k = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, arow('h300 + (k / 4) * 'h100, k % 4), 0, 0, 0, 0);
      if (in_acc) k++;
    end
    chk("stall_rows", 64'(k), 64'd8);
    chk("stall_level", 64'(level), 64'd2);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    budget = 0;
    while (k < 12 && budget < 40) begin
      cyc(1, arow('h300 + (k / 4) * 'h100, k % 4), 0, 0, 1, 0);
      if (in_acc) k++;
      budget++;
    end
    chk("stall_done", 64'(k), 64'd12);
    for (int i = 0; i < 12; i++) cyc(0, '0, 0, 0, 1, 0);

    // Flush a partial matrix between two full ones
    for (int r = 0; r < N; r++) cyc(1, arow('h500, r), 0, 0, 0, 0);
    for (int r = 0; r < 2; r++) cyc(1, arow('h600, r), 0, 0, 0, 0);
    cyc(1, arow('h600, 2), 0, 1, 0, 0);
    for (int r = 0; r < N; r++) cyc(1, arow('h700, r), 1, 0, 0, 0);
    chk("flush_level", 64'(level), 64'd2);
    for (int i = 0; i < 10; i++) cyc(0, '0, 0, 0, 1, 0);
    chk("flush_empty", 64'(level), 64'd0);

    // Reset in the middle of a drain
    for (int r = 0; r < N; r++) cyc(1, arow('h800, r), 0, 0, 1, 0);
    cyc(0, '0, 0, 0, 1, 0);
    cyc(0, '0, 0, 0, 1, 0);
    cyc(0, '0, 0, 0, 1, 1);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_level", 64'(level), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_out_data", out_data, 64'd0);
    for (int r = 0; r < N; r++) cyc(1, arow('h900, r), 0, 0, 1, 0);
    chk("mrst_fresh", out_data, 64'h0930_0920_0910_0900);
    for (int i = 0; i < N + 2; i++) cyc(0, '0, 0, 0, 1, 0);

    // Random traffic with held-until-accepted input rows
    pend  = 1'b0;
    pdata = '0;
    prev  = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!pend && ($urandom % 4) != 0) begin
        pend  = 1'b1;
        pdata = {$urandom, $urandom};
        prev  = 1'($urandom);
      end
      cyc(pend, pdata, prev, ($urandom % 25) == 0,
          ($urandom % 3) != 0, 1'b0);
      if (in_acc) pend = 1'b0;
    end
    for (int i = 0; i < 12; i++) cyc(0, '0, 0, 0, 1, 0);
    chk("final_level", 64'(level), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
